// File: rtl/div_clk_monitor.sv
// Monitors the divide-by-16 clock as sampled data: ticks, period measurement, lock FSM, error flags.
// Optional high-time (duty) checking is enabled by defining DIV_MON_DUTY_EN.
module div_clk_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 16,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned EXP_HIGH   = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_clk,
    output logic             tick_out,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_stall,
    output logic [7:0]       err_count
`ifdef DIV_MON_DUTY_EN
    ,
    output logic             err_duty
`endif
);

    if ((TIMEOUT >= (1 << CNT_W)) || (TIMEOUT <= EXP_PERIOD + TOL) ||
        (LOCK_CNT < 1) || (EXP_HIGH >= EXP_PERIOD)) begin : g_param_check
        $error("div_clk_monitor: inconsistent parameter set");
    end

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0]   P_EXP     = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   P_TOL     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]   P_MAX     = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] P_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             s0_q, s1_q, prev_q;
    logic             rise, good, stall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_x;
    logic [GW-1:0]    good_q, good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             tick_q, tick_d;
    logic             pv_q, pv_d;
    logic             ep_q, ep_d;
    logic             es_q, es_d;
    logic [7:0]       errc_q, errc_d;
    logic [1:0]       n_err;
    logic [8:0]       errc_sum;

    assign rise  = s1_q & ~prev_q;
    assign cnt_x = {1'b0, cnt_q};
    // Lower bound written as cnt+TOL >= EXP so it cannot underflow.
    assign good  = (cnt_x + P_TOL >= P_EXP) && (cnt_x <= P_MAX);
    assign stall = (cnt_q == P_TIMEOUT) && !rise;

`ifdef DIV_MON_DUTY_EN
    localparam logic [CNT_W:0] P_HIGH     = (CNT_W+1)'(EXP_HIGH);
    localparam logic [CNT_W:0] P_HIGH_MAX = (CNT_W+1)'(EXP_HIGH + 1);

    logic             fall;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W:0]   hi_x;
    logic             ed_q, ed_d;

    assign fall = ~s1_q & prev_q;
    assign hi_x = {1'b0, hi_q};
`endif

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = period_q;
        pv_d     = 1'b0;
        ep_d     = 1'b0;
        es_d     = 1'b0;
        tick_d   = rise & enable;

        if (!enable || state_q == IDLE) cnt_d = '0;
        else if (rise)                  cnt_d = CNT_W'(1);
        else if (cnt_q != '1)           cnt_d = cnt_q + CNT_W'(1);
        else                            cnt_d = cnt_q;

        if (!enable) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    if (rise) begin
                        state_d = TRACK;
                        good_d  = '0;
                    end else if (stall) begin
                        es_d = 1'b1;
                    end
                end
                TRACK, LOCKED: begin
                    if (rise) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        if (!good) begin
                            ep_d    = 1'b1;
                            good_d  = '0;
                            state_d = TRACK;
                        end else if (state_q == TRACK) begin
                            good_d = good_q + GW'(1);
                            if (good_q == GW'(LOCK_CNT - 1)) state_d = LOCKED;
                        end
                    end else if (stall) begin
                        es_d    = 1'b1;
                        state_d = ACQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef DIV_MON_DUTY_EN
        // The rise sample itself is the first high sample.
        if (rise)                   hi_d = CNT_W'(1);
        else if (s1_q && hi_q != '1) hi_d = hi_q + CNT_W'(1);
        else                        hi_d = hi_q;
        ed_d = enable && fall && (state_q == TRACK || state_q == LOCKED) &&
               ((hi_x > P_HIGH_MAX) || (hi_x + (CNT_W+1)'(1) < P_HIGH));
        n_err = {1'b0, ep_d} + {1'b0, es_d} + {1'b0, ed_d};
`else
        n_err = {1'b0, ep_d} + {1'b0, es_d};
`endif
        errc_sum = {1'b0, errc_q} + {7'd0, n_err};
        errc_d   = errc_sum[8] ? 8'hFF : errc_sum[7:0];
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
            pv_q     <= 1'b0;
            ep_q     <= 1'b0;
            es_q     <= 1'b0;
            errc_q   <= '0;
`ifdef DIV_MON_DUTY_EN
            hi_q     <= '0;
            ed_q     <= 1'b0;
`endif
        end else begin
            s0_q     <= div_clk;
            s1_q     <= s0_q;
            prev_q   <= s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            pv_q     <= pv_d;
            ep_q     <= ep_d;
            es_q     <= es_d;
            errc_q   <= errc_d;
`ifdef DIV_MON_DUTY_EN
            hi_q     <= hi_d;
            ed_q     <= ed_d;
`endif
        end
    end

    assign tick_out     = tick_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = (state_q == LOCKED);
    assign err_period   = ep_q;
    assign err_stall    = es_q;
    assign err_count    = errc_q;
`ifdef DIV_MON_DUTY_EN
    assign err_duty     = ed_q;
`endif

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed self-checking bench for div_clk_monitor; event counters sampled on the falling clk_in edge.
module tb_div_clk_monitor;

    logic       clk_in = 1'b0;
    logic       reset, enable, div_clk;
    logic       tick_out, period_valid, locked, err_period, err_stall;
    logic [7:0] period, err_count;
`ifdef DIV_MON_DUTY_EN
    logic       err_duty;
`endif

    int   n_tests = 0, n_fail = 0;
    int   n_tick, n_pv, n_ep, n_es, n_ed, n_lock_rise;
    logic lock_rise_pv = 1'b0, locked_prev = 1'b0;

    always #5 clk_in = ~clk_in;

    div_clk_monitor #(
        .CNT_W(8), .EXP_PERIOD(16), .TOL(1), .LOCK_CNT(4), .TIMEOUT(64), .EXP_HIGH(2)
    ) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .div_clk(div_clk),
        .tick_out(tick_out), .period(period), .period_valid(period_valid),
        .locked(locked), .err_period(err_period), .err_stall(err_stall),
        .err_count(err_count)
`ifdef DIV_MON_DUTY_EN
        , .err_duty(err_duty)
`endif
    );

    always @(negedge clk_in) begin
        if (tick_out)     n_tick++;
        if (period_valid) n_pv++;
        if (err_period)   n_ep++;
        if (err_stall)    n_es++;
`ifdef DIV_MON_DUTY_EN
        if (err_duty)     n_ed++;
`endif
        if (locked && !locked_prev) begin
            n_lock_rise++;
            lock_rise_pv = period_valid;
        end
        locked_prev = locked;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_tick = 0; n_pv = 0; n_ep = 0; n_es = 0; n_ed = 0; n_lock_rise = 0;
    endtask

    task automatic cyc(input logic d);
        div_clk = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic per(input int p, input int h);
        for (int i = 0; i < p; i++) cyc(i < h);
    endtask

    initial begin
        clr();
        reset = 1'b1; enable = 1'b0; div_clk = 1'b0;
        repeat (3) cyc(0);
        check("rst_tick", tick_out, 0);
        check("rst_pv", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_errs", {err_period, err_stall}, 0);
        check("rst_errcnt", err_count, 0);
        reset = 1'b0;

        // Disabled: synchroniser runs but no ticks.
        cyc(0); clr();
        repeat (3) per(16, 2);
        check("dis_ticks", n_tick, 0);
        check("dis_pv", n_pv, 0);
        check("dis_locked", locked, 0);

        // Nominal lock, first tick exactly 3 edges after first high sample.
        enable = 1'b1;
        cyc(0); cyc(0); clr();
        cyc(1); cyc(1);
        check("tick_early", tick_out, 0);
        cyc(0);
        check("tick_first", tick_out, 1);
        repeat (13) cyc(0);
        repeat (3) per(16, 2);
        check("nom_pv4", n_pv, 3);
        check("nom_unlocked4", locked, 0);
        per(16, 2);
        check("nom_locked5", locked, 1);
        check("nom_ticks", n_tick, 5);
        check("nom_pv", n_pv, 4);
        check("nom_period", period, 16);
        check("nom_lock_with_pv", {n_lock_rise[7:0], 7'd0, lock_rise_pv}, {8'd1, 8'd1});
        check("nom_errs", n_ep + n_es, 0);
        check("nom_errcnt", err_count, 0);
`ifdef DIV_MON_DUTY_EN
        check("nom_duty", n_ed, 0);
`endif

        // Tolerance edges 15 and 17.
        clr();
        per(15, 2); per(17, 2); per(16, 2);
        check("tol_ep", n_ep, 0);
        check("tol_locked", locked, 1);
        check("tol_period", period, 17);
        check("tol_pv", n_pv, 3);

        // Period 18 while locked, then relock.
        clr();
        per(18, 2); per(16, 2);
        check("p18_ep", n_ep, 1);
        check("p18_locked", locked, 0);
        check("p18_errcnt", err_count, 1);
        check("p18_period", period, 18);
        repeat (3) per(16, 2);
        check("p18_relock3", locked, 0);
        per(16, 2);
        check("p18_relock4", locked, 1);
        check("p18_errcnt2", err_count, 1);

        // Stall while locked.
        clr();
        repeat (80) cyc(0);
        check("stall_es", n_es, 1);
        check("stall_locked", locked, 0);
        check("stall_errcnt", err_count, 2);
        check("stall_ep", n_ep, 0);
        repeat (200) cyc(0);
        check("stall_once", n_es, 1);
        clr();
        per(16, 2);
        check("restart_pv", n_pv, 0);
        check("restart_tick", n_tick, 1);
        repeat (3) per(16, 2);
        check("restart_unlocked", locked, 0);
        per(16, 2);
        check("restart_locked", locked, 1);
        check("restart_pv4", n_pv, 4);
        check("restart_noerr", n_es + n_ep, 0);

        // Rise exactly at cnt == TIMEOUT: period error, no stall.
        clr();
        per(64, 2); per(16, 2);
        check("sim_ep", n_ep, 1);
        check("sim_es", n_es, 0);
        check("sim_period", period, 64);
        check("sim_locked", locked, 0);
        check("sim_errcnt", err_count, 3);
        repeat (4) per(16, 2);
        check("sim_relock", locked, 1);

        // Asynchronous reset with a tick in flight.
        cyc(1); cyc(1); cyc(0);
        check("pre_rst_tick", tick_out, 1);
        check("pre_rst_errcnt", err_count, 3);
        reset = 1'b1;
        #1;
        check("mid_rst_tick", tick_out, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_errcnt", err_count, 0);
        check("mid_rst_pulses", {period_valid, err_period, err_stall}, 0);
        cyc(0); cyc(0);
        reset = 1'b0;

        // Saturation via repeated stalls in ACQ.
        clr();
        for (int k = 0; k < 300; k++) begin
            enable = 1'b1;
            repeat (70) cyc(0);
            enable = 1'b0;
            repeat (2) cyc(0);
        end
        check("sat_es", n_es, 300);
        check("sat_errcnt", err_count, 255);
        for (int k = 0; k < 5; k++) begin
            enable = 1'b1;
            repeat (70) cyc(0);
            enable = 1'b0;
            repeat (2) cyc(0);
        end
        check("sat_es2", n_es, 305);
        check("sat_hold", err_count, 255);

`ifdef DIV_MON_DUTY_EN
        // High time 5: duty error every period, lock unaffected.
        reset = 1'b1; cyc(0); cyc(0); reset = 1'b0;
        enable = 1'b1;
        cyc(0); cyc(0); clr();
        repeat (8) per(16, 5);
        check("duty_ed", n_ed, 8);
        check("duty_locked", locked, 1);
        check("duty_ep", n_ep, 0);
        check("duty_errcnt", err_count, 8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Sits directly downstream of the divide-by-16 clock divider, in the same clk_in domain.
- Samples the divided clock as data through a 2-flop synchroniser and detects its rising edges.
- Emits one-cycle ticks and measures the period in clk_in cycles.
- Runs a lock FSM that asserts locked after consecutive in-tolerance periods, and flags period errors and stalls.

Parameters:
- CNT_W, 8, width of period counter and period output; must hold TIMEOUT.
- EXP_PERIOD, 16, expected div_clk period in clk_in cycles.
- TOL, 1, allowed absolute deviation from EXP_PERIOD.
- LOCK_CNT, 4, consecutive good periods required to lock (>=1).
- TIMEOUT, 64, clk_in cycles without a rise that declare a stall; must exceed EXP_PERIOD+TOL.
- EXP_HIGH, 2, expected div_clk high time in samples (used only with the optional feature).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  monitor enable; low forces IDLE.
- div_clk  input  1  divided clock, treated as asynchronous data.
- tick_out  output  1  one-cycle pulse per detected div_clk rise.
- period  output  CNT_W  last measured period; holds between updates.
- period_valid  output  1  one-cycle pulse when period updates.
- locked  output  1  high in LOCKED state.
- err_period  output  1  one-cycle pulse on out-of-tolerance period.
- err_stall  output  1  one-cycle pulse on timeout.
- err_count  output  8  saturating count of err_period plus err_stall events.

Behaviour:
- Reset: clk_in and reset are the single clock and asynchronous active-high reset. All flops clear on reset assertion: sync flops, prev, cnt, state=IDLE, and every output 0. Reset mid-operation aborts immediately with no pending pulses.
- Synchroniser: s0<=div_clk, s1<=s0, prev<=s1. rise = s1 & ~prev.
- Tick timing: tick_out is registered from rise. If div_clk is first sampled high at edge k, tick_out is high during the cycle after edge k+2.
- Tick gating: the synchroniser runs regardless of enable; tick_out is gated by enable.
- cnt (CNT_W bits): on rise it loads 1; otherwise it increments, saturating at all-ones. It clears to 0 in IDLE. At a rise, cnt equals the number of clk_in cycles since the previous rise.
- Period check: good = (cnt >= EXP_PERIOD-TOL) && (cnt <= EXP_PERIOD+TOL). Comparisons are unsigned, CNT_W+1 wide, with no underflow.
- Stall: stall = (cnt == TIMEOUT) && !rise. It fires once per stall because cnt passes TIMEOUT and saturates.
- FSM states IDLE, ACQ, TRACK, LOCKED. Any state with enable=0 goes to IDLE on the next edge, which clears locked, cnt and good_cnt. period and err_count hold.
- IDLE: enable=1 -> ACQ.
- ACQ: on rise -> TRACK with good_cnt=0. The first rise gives no period_valid, because there is no reference edge. On stall, pulse err_stall and stay in ACQ.
- TRACK: on rise, period<=cnt and pulse period_valid.
  - If good, good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - If bad, pulse err_period, set good_cnt=0 and stay in TRACK.
  - On stall, pulse err_stall and go to ACQ.
- LOCKED: locked=1. On rise, update period and pulse period_valid. A bad period pulses err_period and goes to TRACK with good_cnt=0. A stall pulses err_stall and goes to ACQ.
- Simultaneous rise and cnt==TIMEOUT: the rise wins and stall is suppressed. The period is evaluated and is necessarily bad.
- Lock latency: LOCK_CNT good periods after the first rise. locked rises on the edge that registers the LOCK_CNT-th good period, together with its period_valid.
- err_count: increments by 1 on each error pulse and saturates at 255. It clears only on reset.

Optional Feature:
- Macro: DIV_MON_DUTY_EN.
- When defined:
  - Adds a high-time counter: cleared on rise, incremented while s1=1.
  - Adds output err_duty (1 bit, reset 0). On the falling edge (~s1 & prev) in TRACK or LOCKED, a high-time differing from EXP_HIGH by more than 1 pulses err_duty for one cycle.
  - A duty error increments err_count but does not affect lock.
- When undefined: no high-time counter and no err_duty port; behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert reset mid-stream with div_clk toggling -> all outputs 0 immediately; with enable=0, tick_out stays 0 even while div_clk toggles.
- Nominal lock:
  - Stimulus: enable=1, div_clk period 16, high 2 cycles.
  - Ticks and periods: tick_out every 16 cycles, first tick 3 edges after the first high sample; period=16 with period_valid from the 2nd rise on.
  - Lock: locked=1 at the 5th rise; no errors.
- Tolerance edges:
  - Periods 15 and 17 -> good, locked holds.
  - Period 18 while locked -> err_period pulse, locked=0, err_count=1, then relock after 4 good periods.
- Stall: stop div_clk while locked -> err_stall exactly once when cnt hits 64, state ACQ, locked=0; restart -> no period_valid on the first rise, relock after 4 more good periods.
- Saturation/simultaneity: 300 stalls -> err_count=255 and stays there; rise arriving exactly at cnt=64 -> err_period pulses and err_stall does not.
- With DIV_MON_DUTY_EN, high time 5 cycles -> err_duty pulses each period while lock is kept.
